// File: rtl/prod_accumulator.sv
// rtl/prod_accumulator.sv - burst accumulator behind the 32x32 multiplier.
// Optional clamp-on-overflow behaviour: define PROD_ACC_SAT_EN.
module prod_accumulator #(
  parameter int PROD_W  = 64,
  parameter int GUARD_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PROD_W-1:0]         in_prod,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PROD_W+GUARD_W-1:0] out_acc,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_ovf
);

  localparam int ACC_W = PROD_W + GUARD_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_base, acc_n;
  logic [CNT_W-1:0]   count, cnt_base, cnt_n;
  logic               ovf, ovf_base, ovf_n;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               accept;

  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = in_last ? IDLE : ACCUM;
  end

  // A burst always starts from zero when no beat has been absorbed yet.
  always_comb begin
    acc_base = '0;
    cnt_base = '0;
    ovf_base = 1'b0;
    if (state == ACCUM) begin
      acc_base = acc;
      cnt_base = count;
      ovf_base = ovf;
    end
  end

  assign sum   = {1'b0, acc_base} + {{(GUARD_W + 1){1'b0}}, in_prod};
  assign carry = sum[ACC_W];

`ifdef PROD_ACC_SAT_EN
  // Once clamped, any further non-zero beat carries again, so the clamp persists.
  assign acc_n = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_n = sum[ACC_W-1:0];
`endif

  assign cnt_n = (&cnt_base) ? cnt_base : cnt_base + {{(CNT_W - 1){1'b0}}, 1'b1};
  assign ovf_n = ovf_base | carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr || (accept && in_last)) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_n;
      count <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  // Output holding stage; a consumed result can be replaced in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept && in_last) begin
      out_valid <= 1'b1;
      out_acc   <= acc_n;
      out_count <= cnt_n;
      out_ovf   <= ovf_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// tb/tb_prod_accumulator.sv - randomized and directed checks of prod_accumulator against a burst-level model.
module tb_prod_accumulator;

  localparam logic [127:0] LIM = 128'h1 << 72;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_acc;
  logic [15:0] out_count;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  prod_accumulator dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Model: exact burst sum in wide arithmetic, reduced to the 72-bit view only at publish time.
  logic         cur_valid = 0, nxt_valid = 0;
  logic [71:0]  cur_acc = 0, nxt_acc = 0;
  logic [15:0]  cur_cnt = 0, nxt_cnt = 0;
  logic         cur_ovf = 0, nxt_ovf = 0;
  logic [127:0] cur_bsum = 0, nxt_bsum = 0;
  int           cur_bcnt = 0, nxt_bcnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic model_clear();
    cur_valid = 0; nxt_valid = 0; cur_acc = 0; nxt_acc = 0;
    cur_cnt = 0; nxt_cnt = 0; cur_ovf = 0; nxt_ovf = 0;
    cur_bsum = 0; nxt_bsum = 0; cur_bcnt = 0; nxt_bcnt = 0;
  endtask

  task automatic step(input bit v, input logic [63:0] p, input bit l, input bit r, input bit c);
    bit           rdy, acc;
    logic [127:0] s;
    int           n;
    @(posedge clk);
    #1;
    cur_valid = nxt_valid; cur_acc = nxt_acc; cur_cnt = nxt_cnt; cur_ovf = nxt_ovf;
    cur_bsum = nxt_bsum; cur_bcnt = nxt_bcnt;
    #1;
    in_valid = v; in_prod = p; in_last = l; out_ready = r; clr = c;
    rdy = !c && (!cur_valid || r);
    acc = v && rdy;
    nxt_valid = (cur_valid && r) ? 1'b0 : cur_valid;
    nxt_bsum = cur_bsum; nxt_bcnt = cur_bcnt;
    if (c) begin
      nxt_bsum = 0; nxt_bcnt = 0;
    end else if (acc) begin
      s = cur_bsum + {64'h0, p};
      n = cur_bcnt + 1;
      if (l) begin
        nxt_valid = 1'b1;
`ifdef PROD_ACC_SAT_EN
        nxt_acc = (s >= LIM) ? {72{1'b1}} : s[71:0];
`else
        nxt_acc = s[71:0];
`endif
        nxt_ovf = (s >= LIM);
        nxt_cnt = (n > 65535) ? 16'hFFFF : 16'(n);
        nxt_bsum = 0; nxt_bcnt = 0;
      end else begin
        nxt_bsum = s; nxt_bcnt = n;
      end
    end
  endtask

  // Single compare process: every cycle out of reset, DUT vs model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, !clr && (!cur_valid || out_ready));
      chk("out_valid", out_valid, cur_valid);
      if (cur_valid) begin
        chk("out_acc", out_acc, cur_acc);
        chk("out_count", out_count, cur_cnt);
        chk("out_ovf", out_ovf, cur_ovf);
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_acc"}, out_acc, 0);
    chk({nm, "_count"}, out_count, 0);
    chk({nm, "_ovf"}, out_ovf, 0);
  endtask

  initial begin
    #1;
    chk_zero("rst0");
    @(posedge clk); #2 rst = 0;

    // Burst 3,5,7
    step(1, 3, 0, 1, 0);
    step(1, 5, 0, 1, 0);
    step(1, 7, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lit_burst_valid", out_valid, 1);
    chk("lit_burst_acc", out_acc, 15);
    chk("lit_burst_count", out_count, 3);
    chk("lit_burst_ovf", out_ovf, 0);

    // Back-to-back single-beat bursts
    for (int i = 0; i < 6; i++) step(1, 64'hFFFF_FFFE_0000_0001, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lit_b2b_acc", out_acc, 72'hFFFF_FFFE_0000_0001);
    chk("lit_b2b_count", out_count, 1);

    // Backpressure, then reload in the cycle out_ready rises
    step(1, 4, 1, 0, 0);
    step(1, 6, 1, 0, 0);
    step(1, 6, 1, 0, 0);
    @(negedge clk);
    chk("lit_bp_ready", in_ready, 0);
    chk("lit_bp_hold", out_acc, 4);
    step(1, 6, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_bp_valid", out_valid, 1);
    chk("lit_bp_reload", out_acc, 6);
    step(0, 0, 0, 1, 0);

    // Overflow: 257 beats of 2^64-1
    for (int i = 0; i < 257; i++) step(1, 64'hFFFF_FFFF_FFFF_FFFF, i == 256, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
`ifdef PROD_ACC_SAT_EN
    chk("lit_ovf_acc", out_acc, {72{1'b1}});
`else
    chk("lit_ovf_acc", out_acc, 72'h00_FFFF_FFFF_FFFF_FEFF);
`endif
    chk("lit_ovf_flag", out_ovf, 1);
    chk("lit_ovf_count", out_count, 257);

    // Abort after two beats, clr together with in_valid
    step(1, 100, 0, 1, 0);
    step(1, 200, 0, 1, 0);
    step(1, 300, 0, 1, 1);
    step(1, 9, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lit_abort_acc", out_acc, 9);
    chk("lit_abort_count", out_count, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] p;
      p = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset in the middle of a burst, with a stale nonzero output
    step(1, 11, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 2, 0, 1, 0);
    @(posedge clk);
    #3;
    in_valid = 0; in_last = 0; clr = 0; out_ready = 0;
    rst = 1;
    model_clear();
    #1;
    chk_zero("rst_mid");
    chk("rst_mid_ready", in_ready, 1);
    @(posedge clk); #2 rst = 0;
    step(1, 2, 0, 1, 0);
    step(1, 3, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lit_post_rst_acc", out_acc, 5);
    chk("lit_post_rst_count", out_count, 2);
    step(0, 0, 0, 1, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Sequential accumulator directly downstream of the 32x32 combinational multiplier. Accepts one 64-bit unsigned product per cycle over a valid/ready handshake and sums a burst of products into a 72-bit accumulator. On the beat flagged `in_last`, it publishes the total, the term count and an overflow flag on a registered output handshake. It is the dot-product / MAC back end for the multiplier datapath.

## Interface
Parameters:
- `PROD_W`, 64: product width; must match the multiplier output.
- `GUARD_W`, 8: guard bits; accumulator width is `PROD_W+GUARD_W` = 72.
- `CNT_W`, 16: width of the term counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous abort; discards the partial sum.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  PROD_W  unsigned product from the multiplier.
- `in_last`  in  1  final beat of the burst.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  PROD_W+GUARD_W  burst sum.
- `out_count`  out  CNT_W  number of beats in the burst.
- `out_ovf`  out  1  burst overflowed 72 bits.

## Operation
- State machine:
  - **IDLE**: accumulator = 0, count = 0, sticky ovf = 0.
  - **ACCUM**: at least one beat absorbed, no `in_last` yet.
- Output register: the `out_valid`/`out_acc`/`out_count`/`out_ovf` holding stage is separate from the state machine.
- `in_ready = !clr && (!out_valid || out_ready)`.
- Accept condition: a beat is accepted when `in_valid && in_ready`.
- On accept:
  - `sum = acc + zero_extend(in_prod)`, computed 73 bits wide; bit 72 is the carry.
  - `cnt_n = count + 1`, saturating at all-ones.
  - `ovf_n = ovf | carry`.
- Accept without `in_last`: acc, count and ovf take the new values; IDLE→ACCUM, or stay in ACCUM.
- Accept with `in_last`:
  - Output registers load `sum`/`cnt_n`/`ovf_n` and `out_valid` is set.
  - acc, count and ovf clear; the state machine goes to IDLE. This applies in IDLE too: a single-beat burst is legal.
- Output handshake: on `out_valid && out_ready`, `out_valid` clears unless a new `in_last` is accepted in the same cycle, in which case the output reloads and `out_valid` stays 1.
- While `out_valid && !out_ready`: `in_ready` = 0 and output values hold stable.
- `clr`:
  - acc, count and ovf clear and the state goes to IDLE next edge; no beat is accepted that cycle.
  - A pending output is unaffected.
- Reset: the state goes to IDLE and all registers, including every output, go to 0. `in_ready` is then 1 (it evaluates to `!clr`). A burst in progress at reset is lost.

## Timing
- Latency: the result appears on `out_valid` the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle, including back-to-back bursts, when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`, `out_ready` and `clr`. There is no combinational path from `in_valid` to `in_ready`.
- The 73-bit add is a single cycle and must close timing at the multiplier clock.

## Configuration
- `PROD_ACC_SAT_EN` defined: on a carry out, the accumulator clamps to all-ones (2^72-1) and stays clamped for the rest of the burst. `out_ovf` = 1.
- `PROD_ACC_SAT_EN` undefined: the accumulator wraps modulo 2^72. `out_ovf` = 1 is still reported.

## Test plan
- Reset: assert `rst` mid-burst → all outputs 0 asynchronously; `in_ready` = 1 after release; the next burst starts from 0.
- Burst: beats 3, 5, 7 (`in_last` on 7), `out_ready` = 1 → one cycle later `out_valid` = 1, `out_acc` = 15, `out_count` = 3, `out_ovf` = 0.
- Back-to-back: single-beat bursts 0xFFFF_FFFE_0000_0001 (= 0xFFFF_FFFF²) every cycle with `out_ready` = 1 → a result every cycle, each with `out_count` = 1.
- Backpressure: `out_ready` = 0 with a result pending → `in_ready` = 0, the output holds; raise `out_ready` while the next `in_last` beat is presented → the output reloads in that same cycle with no bubble.
- Overflow: 2^GUARD_W+1 = 257 beats of 2^64-1 →
  - Without `PROD_ACC_SAT_EN`: `out_acc` = 257·(2^64-1) mod 2^72 and `out_ovf` = 1.
  - With `PROD_ACC_SAT_EN`: `out_acc` = 2^72-1 and `out_ovf` = 1.
- Abort: `clr` asserted after two beats (and together with `in_valid`) → that beat is not accepted; the following burst 9 (`in_last`) gives `out_acc` = 9, `out_count` = 1.
